// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for fifo_reader and its skid buffer.
package fifo_reader_pkg;

   localparam int SKID_DEPTH = 2;
   localparam int RD_LATENCY = 1;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus valid/ready output stream; master is the reader side.
interface fifo_reader_if #(parameter int WIDTH = 8);
   logic             empty;
   logic [WIDTH-1:0] dout;
   logic             pop;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (input empty, input dout, output pop,
                   output m_valid, input m_ready, output m_data);
   modport slave  (output empty, output dout, input pop,
                   input m_valid, output m_ready, input m_data);
endinterface

// File: rtl/fifo_reader_skid_buf.sv
// Two-entry register skid buffer: head slot drives the output, tail absorbs one extra word.
module skid_buf
   import fifo_reader_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output skid_state_t      cnt_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] head_o
);

   skid_state_t      cnt_q, cnt_d;
   logic             valid_q;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      unique case ({push_i, pop_i})
         2'b10: begin
            if (cnt_q == EMPTY) begin
               head_d = push_data_i;
               cnt_d  = ONE;
            end else if (cnt_q == ONE) begin
               tail_d = push_data_i;
               cnt_d  = TWO;
            end
         end
         2'b01: begin
            if (cnt_q == ONE) begin
               cnt_d = EMPTY;
            end else if (cnt_q == TWO) begin
               head_d = tail_q;
               cnt_d  = ONE;
            end
         end
         // Push and pop together: occupancy is unchanged, the queue just advances.
         2'b11: begin
            if (cnt_q == ONE) begin
               head_d = push_data_i;
            end else if (cnt_q == TWO) begin
               head_d = tail_q;
               tail_d = push_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear_i) begin
         cnt_q   <= EMPTY;
         valid_q <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= (cnt_d != EMPTY);
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign valid_o = valid_q;
   assign head_o  = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side consumer for async_fifo: pops, captures dout a cycle later, streams through a skid buffer.
// Optional delivered-word counter port rd_cnt is built when FIFO_READER_CNT_EN is defined.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          rclk,
   input  logic          rst,
   input  logic          flush,
   fifo_reader_if.master bus
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [15:0]   rd_cnt
`endif
);

   skid_state_t      cnt;
   logic             valid;
   logic [WIDTH-1:0] head;
   logic             inflight_q, inflight_d;
   logic             fire;
   logic             pop;
   logic [2:0]       occ;

   assign fire = valid && bus.m_ready;
   assign occ  = 3'(cnt) + 3'(inflight_q);
   // A slot freed by this cycle's fire lets the pop go out now, keeping full throughput.
   assign pop  = !rst && !flush && !bus.empty && ((occ < 3'(SKID_DEPTH)) || fire);
   assign inflight_d = pop;

   always_ff @(posedge rclk) begin
      if (rst) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   skid_buf #(.WIDTH(WIDTH)) u_skid (
      .clk         (rclk),
      .clear_i     (rst || flush),
      .push_i      (inflight_q),
      .push_data_i (bus.dout),
      .pop_i       (fire),
      .cnt_o       (cnt),
      .valid_o     (valid),
      .head_o      (head)
   );

   assign bus.pop     = pop;
   assign bus.m_valid = valid;
   assign bus.m_data  = head;

`ifdef FIFO_READER_CNT_EN
   logic [15:0] rd_cnt_q, rd_cnt_d;

   assign rd_cnt_d = fire ? rd_cnt_q + 16'd1 : rd_cnt_q;

   always_ff @(posedge rclk) begin
      if (rst) begin
         rd_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign rd_cnt = rd_cnt_q;
`endif

   a_no_overflow: assert property (@(posedge rclk) disable iff (rst)
      occ <= 3'(SKID_DEPTH));
   a_inflight_tracks_pop: assert property (@(posedge rclk) disable iff (rst)
      inflight_q == $past(pop, RD_LATENCY));

endmodule
